// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry skid buffer and saturating illegal-opcode counter.
// Optional build macro IMM_GEN_PIPE_FLUSH_EN adds a flush input that empties the buffer.
module imm_gen_pipe #(
   parameter int XLEN      = 64,
   parameter int TAG_W     = 64,
   parameter int ERR_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset,
`ifdef IMM_GEN_PIPE_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output logic [2:0]           out_fmt,
   output logic                 out_illegal,
   output logic [TAG_W-1:0]     out_tag,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {
      FMT_I    = 3'd0,
      FMT_S    = 3'd1,
      FMT_B    = 3'd2,
      FMT_U    = 3'd3,
      FMT_J    = 3'd4,
      FMT_NONE = 3'd7
   } fmt_t;

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;
   fmt_t            dec_fmt;
   logic            dec_illegal;

   logic [XLEN-1:0]  imm_q     [2];
   fmt_t             fmt_q     [2];
   logic             illegal_q [2];
   logic [TAG_W-1:0] tag_q     [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   logic push;
   logic pop;
   logic do_flush;

   // Every immediate is first assembled as a 32-bit signed value, then widened to XLEN.
   always_comb begin
      dec_imm32   = '0;
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b1;
      unique case (in_instr[6:0])
         OP_IMM, OP_LOAD, OP_JALR: begin
            dec_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            dec_fmt     = FMT_I;
            dec_illegal = 1'b0;
         end
         OP_IMM_32: begin
            if (XLEN == 64) begin
               dec_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
               dec_fmt     = FMT_I;
               dec_illegal = 1'b0;
            end
         end
         OP_STORE: begin
            dec_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            dec_fmt     = FMT_S;
            dec_illegal = 1'b0;
         end
         OP_BRANCH: begin
            dec_imm32   = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            dec_fmt     = FMT_B;
            dec_illegal = 1'b0;
         end
         OP_LUI, OP_AUIPC: begin
            dec_imm32   = {in_instr[31:12], 12'h000};
            dec_fmt     = FMT_U;
            dec_illegal = 1'b0;
         end
         OP_JAL: begin
            dec_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            dec_fmt     = FMT_J;
            dec_illegal = 1'b0;
         end
         default: begin
            dec_imm32   = '0;
            dec_fmt     = FMT_NONE;
            dec_illegal = 1'b1;
         end
      endcase
      dec_imm = XLEN'($signed(dec_imm32));
   end

   // in_ready depends only on the registered count, never on out_ready.
   assign in_ready  = (count < 2'd2);
   assign out_valid = (count != 2'd0);

`ifdef IMM_GEN_PIPE_FLUSH_EN
   assign do_flush = flush;
`else
   assign do_flush = 1'b0;
`endif

   assign push = in_valid && in_ready && !do_flush;
   assign pop  = out_valid && out_ready && !do_flush;

   // Storage is zeroed at reset so the outputs are defined even while empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            imm_q[i]     <= '0;
            fmt_q[i]     <= FMT_I;
            illegal_q[i] <= 1'b0;
            tag_q[i]     <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (do_flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            imm_q[wr_ptr]     <= dec_imm;
            fmt_q[wr_ptr]     <= dec_fmt;
            illegal_q[wr_ptr] <= dec_illegal;
            tag_q[wr_ptr]     <= in_tag;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         if (push && !pop) begin
            count <= count + 2'd1;
         end else if (pop && !push) begin
            count <= count - 2'd1;
         end
      end
   end

   // Counts accepted illegal instructions; a flushed push is never accepted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (push && dec_illegal && (err_cnt != {ERR_CNT_W{1'b1}})) begin
         err_cnt <= err_cnt + 1'b1;
      end
   end

   assign out_imm     = imm_q[rd_ptr];
   assign out_fmt     = fmt_q[rd_ptr];
   assign out_illegal = illegal_q[rd_ptr];
   assign out_tag     = tag_q[rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: an XLEN=64 instance and an XLEN=32 instance with a 2-bit error counter.
// Exercises the IMM_GEN_PIPE_FLUSH_EN flush path when that macro is defined.
module tb_imm_gen_pipe;

   logic        clk;
   logic        reset;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
   logic [31:0] a_in_instr;
   logic [63:0] a_in_tag, a_out_imm, a_out_tag;
   logic [2:0]  a_out_fmt;
   logic [15:0] a_err_cnt;
   logic        a_flush;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
   logic [31:0] b_in_instr;
   logic [7:0]  b_in_tag, b_out_tag;
   logic [31:0] b_out_imm;
   logic [2:0]  b_out_fmt;
   logic [1:0]  b_err_cnt;
   logic        b_flush;

   int checks;
   int errors;

   imm_gen_pipe #(.XLEN(64), .TAG_W(64), .ERR_CNT_W(16)) dut_a (
      .clk         (clk),
      .reset       (reset),
`ifdef IMM_GEN_PIPE_FLUSH_EN
      .flush       (a_flush),
`endif
      .in_valid    (a_in_valid),
      .in_ready    (a_in_ready),
      .in_instr    (a_in_instr),
      .in_tag      (a_in_tag),
      .out_valid   (a_out_valid),
      .out_ready   (a_out_ready),
      .out_imm     (a_out_imm),
      .out_fmt     (a_out_fmt),
      .out_illegal (a_out_illegal),
      .out_tag     (a_out_tag),
      .err_cnt     (a_err_cnt)
   );

   imm_gen_pipe #(.XLEN(32), .TAG_W(8), .ERR_CNT_W(2)) dut_b (
      .clk         (clk),
      .reset       (reset),
`ifdef IMM_GEN_PIPE_FLUSH_EN
      .flush       (b_flush),
`endif
      .in_valid    (b_in_valid),
      .in_ready    (b_in_ready),
      .in_instr    (b_in_instr),
      .in_tag      (b_in_tag),
      .out_valid   (b_out_valid),
      .out_ready   (b_out_ready),
      .out_imm     (b_out_imm),
      .out_fmt     (b_out_fmt),
      .out_illegal (b_out_illegal),
      .out_tag     (b_out_tag),
      .err_cnt     (b_err_cnt)
   );

   // 10-unit clock; stimulus and sampling happen 1 unit after each rising edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h", name, obs, exp);
      end
   endtask

   // Presents one instruction for a single edge on the chosen instance.
   task automatic applyStimulus(input bit to_b, input logic [31:0] instr, input logic [63:0] tag);
      if (to_b) begin
         b_in_instr = instr;
         b_in_tag   = tag[7:0];
         b_in_valid = 1'b1;
      end else begin
         a_in_instr = instr;
         a_in_tag   = tag;
         a_in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
   endtask

   function automatic logic [31:0] addi_x1(input logic [11:0] v);
      return {v, 5'd0, 3'd0, 5'd1, 7'h13};
   endfunction

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      a_in_valid  = 1'b0;  a_in_instr = '0; a_in_tag = '0; a_out_ready = 1'b1; a_flush = 1'b0;
      b_in_valid  = 1'b0;  b_in_instr = '0; b_in_tag = '0; b_out_ready = 1'b1; b_flush = 1'b0;

      #2;
      checkOutput("rst_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("rst_in_ready", 64'(a_in_ready), 64'd1);
      checkOutput("rst_out_imm", a_out_imm, 64'd0);
      checkOutput("rst_out_fmt", 64'(a_out_fmt), 64'd0);
      checkOutput("rst_out_illegal", 64'(a_out_illegal), 64'd0);
      checkOutput("rst_out_tag", a_out_tag, 64'd0);
      checkOutput("rst_err_cnt", 64'(a_err_cnt), 64'd0);

      @(posedge clk);
      #1;
      reset = 1'b0;

      // Format decode on the 64-bit instance, out_ready held high.
      applyStimulus(1'b0, 32'hFFF00093, 64'h10);
      checkOutput("addi_valid", 64'(a_out_valid), 64'd1);
      checkOutput("addi_imm", a_out_imm, 64'hFFFFFFFFFFFFFFFF);
      checkOutput("addi_fmt", 64'(a_out_fmt), 64'd0);
      checkOutput("addi_illegal", 64'(a_out_illegal), 64'd0);
      checkOutput("addi_tag", a_out_tag, 64'h10);

      applyStimulus(1'b0, 32'hFE513C23, 64'h11);
      checkOutput("sd_imm", a_out_imm, 64'hFFFFFFFFFFFFFFF8);
      checkOutput("sd_fmt", 64'(a_out_fmt), 64'd1);

      applyStimulus(1'b0, 32'hFE000EE3, 64'h12);
      checkOutput("beq_imm", a_out_imm, 64'hFFFFFFFFFFFFFFFC);
      checkOutput("beq_fmt", 64'(a_out_fmt), 64'd2);

      applyStimulus(1'b0, 32'h800000B7, 64'h13);
      checkOutput("lui_imm", a_out_imm, 64'hFFFFFFFF80000000);
      checkOutput("lui_fmt", 64'(a_out_fmt), 64'd3);

      applyStimulus(1'b0, 32'hFFDFF06F, 64'h14);
      checkOutput("jal_imm", a_out_imm, 64'hFFFFFFFFFFFFFFFC);
      checkOutput("jal_fmt", 64'(a_out_fmt), 64'd4);

      applyStimulus(1'b0, 32'h0050009B, 64'h15);
      checkOutput("addiw64_imm", a_out_imm, 64'd5);
      checkOutput("addiw64_fmt", 64'(a_out_fmt), 64'd0);
      checkOutput("addiw64_illegal", 64'(a_out_illegal), 64'd0);

      applyStimulus(1'b0, 32'h0000007F, 64'h16);
      checkOutput("ill_imm", a_out_imm, 64'd0);
      checkOutput("ill_fmt", 64'(a_out_fmt), 64'd7);
      checkOutput("ill_illegal", 64'(a_out_illegal), 64'd1);
      checkOutput("ill_err_cnt", 64'(a_err_cnt), 64'd1);

      @(posedge clk);
      #1;
      checkOutput("drain_out_valid", 64'(a_out_valid), 64'd0);

      // Backpressure: tags 1,2,3 offered back-to-back with out_ready low.
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_instr  = addi_x1(12'd1);
      a_in_tag    = 64'd1;
      @(posedge clk);
      #1;
      a_in_instr  = addi_x1(12'd2);
      a_in_tag    = 64'd2;
      @(posedge clk);
      #1;
      checkOutput("bp_in_ready_full", 64'(a_in_ready), 64'd0);
      a_in_instr  = addi_x1(12'd3);
      a_in_tag    = 64'd3;
      @(posedge clk);
      #1;
      checkOutput("bp_stall_tag", a_out_tag, 64'd1);
      checkOutput("bp_stall_imm", a_out_imm, 64'd1);
      @(posedge clk);
      #1;
      checkOutput("bp_stable_tag", a_out_tag, 64'd1);
      checkOutput("bp_stable_imm", a_out_imm, 64'd1);
      checkOutput("bp_stable_in_ready", 64'(a_in_ready), 64'd0);
      a_out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_second_tag", a_out_tag, 64'd2);
      checkOutput("bp_second_imm", a_out_imm, 64'd2);
      checkOutput("bp_ready_again", 64'(a_in_ready), 64'd1);
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      checkOutput("bp_third_tag", a_out_tag, 64'd3);
      checkOutput("bp_third_valid", 64'(a_out_valid), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("bp_empty_valid", 64'(a_out_valid), 64'd0);

      // 32-bit instance: narrow sign extension, OP-IMM-32 rejected, counter saturation.
      applyStimulus(1'b1, 32'h800000B7, 64'h21);
      checkOutput("b_lui_imm", 64'(b_out_imm), 64'h0000000080000000);
      checkOutput("b_lui_fmt", 64'(b_out_fmt), 64'd3);
      checkOutput("b_lui_tag", 64'(b_out_tag), 64'h21);
      applyStimulus(1'b1, 32'h0050009B, 64'h22);
      checkOutput("b_addiw_fmt", 64'(b_out_fmt), 64'd7);
      checkOutput("b_addiw_illegal", 64'(b_out_illegal), 64'd1);
      checkOutput("b_addiw_imm", 64'(b_out_imm), 64'd0);
      checkOutput("b_err_cnt_1", 64'(b_err_cnt), 64'd1);
      applyStimulus(1'b1, 32'h0000007F, 64'h23);
      applyStimulus(1'b1, 32'h0000007F, 64'h24);
      checkOutput("b_err_cnt_3", 64'(b_err_cnt), 64'd3);
      applyStimulus(1'b1, 32'h0000007F, 64'h25);
      applyStimulus(1'b1, 32'h0000007F, 64'h26);
      checkOutput("b_err_cnt_sat", 64'(b_err_cnt), 64'd3);

      // Asynchronous reset while the 64-bit buffer holds two entries.
      a_out_ready = 1'b0;
      applyStimulus(1'b0, 32'h0000007F, 64'h31);
      applyStimulus(1'b0, 32'h800000B7, 64'h32);
      checkOutput("pre_rst_in_ready", 64'(a_in_ready), 64'd0);
      checkOutput("pre_rst_err_cnt", 64'(a_err_cnt), 64'd2);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("arst_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("arst_err_cnt", 64'(a_err_cnt), 64'd0);
      checkOutput("arst_in_ready", 64'(a_in_ready), 64'd1);
      checkOutput("arst_out_tag", a_out_tag, 64'd0);
      checkOutput("arst_b_err_cnt", 64'(b_err_cnt), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

`ifdef IMM_GEN_PIPE_FLUSH_EN
      // Flush with a simultaneous illegal push: buffer empties and the counter is untouched.
      applyStimulus(1'b0, 32'h0000007F, 64'h41);
      checkOutput("fl_pre_valid", 64'(a_out_valid), 64'd1);
      checkOutput("fl_pre_err_cnt", 64'(a_err_cnt), 64'd1);
      a_flush    = 1'b1;
      a_in_valid = 1'b1;
      a_in_instr = 32'h0000007F;
      a_in_tag   = 64'h42;
      @(posedge clk);
      #1;
      a_flush    = 1'b0;
      a_in_valid = 1'b0;
      checkOutput("fl_out_valid", 64'(a_out_valid), 64'd0);
      checkOutput("fl_in_ready", 64'(a_in_ready), 64'd1);
      checkOutput("fl_err_cnt", 64'(a_err_cnt), 64'd1);
      a_out_ready = 1'b1;
      applyStimulus(1'b0, 32'hFFF00093, 64'h43);
      checkOutput("fl_after_tag", a_out_tag, 64'h43);
      checkOutput("fl_after_imm", a_out_imm, 64'hFFFFFFFFFFFFFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
